// File: rtl/match_scoreboard_pkg.sv
// Shared types and tables for the match scoreboard: winner codes, blink FSM
// states, the BCD saturation limit and the 7-segment glyph lookup.
package match_scoreboard_pkg;

    typedef enum logic [1:0] {
        WIN_NONE_DRAW = 2'b00,
        WIN_P1        = 2'b01,
        WIN_P2        = 2'b10,
        WIN_BAD       = 2'b11
    } winner_e;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBlink = 1'b1
    } blink_state_e;

    localparam logic [7:0] BCD_MAX = 8'h99;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}; non-decimal codes go dark.
    function automatic logic [6:0] seg7_glyph(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = 7'h3F;
            4'd1:    glyph = 7'h06;
            4'd2:    glyph = 7'h5B;
            4'd3:    glyph = 7'h4F;
            4'd4:    glyph = 7'h66;
            4'd5:    glyph = 7'h6D;
            4'd6:    glyph = 7'h7D;
            4'd7:    glyph = 7'h07;
            4'd8:    glyph = 7'h7F;
            4'd9:    glyph = 7'h6F;
            default: glyph = 7'h00;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/match_scoreboard_bcd2_sat_inc.sv
// Two-digit BCD incrementer that holds at 99 instead of wrapping.
module bcd2_sat_inc
    import match_scoreboard_pkg::*;
(
    input  logic [7:0] value,
    output logic [7:0] result
);

    always_comb begin
        result = value;
        if (value == BCD_MAX) begin
            result = BCD_MAX;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/match_scoreboard.sv
// Match tally keeper: counts P1/P2/draw results on each game-over rising edge,
// multiplexes the two player scores onto a 4-digit 7-segment display and blinks the winner.
module match_scoreboard
    import match_scoreboard_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned BLINK_DIV      = 12500000,
    parameter int unsigned BLINK_TOGGLES  = 8,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       over,
    input  logic [1:0] winner,
    input  logic       clear_scores,
    output logic [6:0] seg,
    output logic [3:0] dig_sel,
    output logic [7:0] p1_bcd,
    output logic [7:0] p2_bcd,
    output logic [7:0] draw_bcd,
    output logic       score_event
);

    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned TogW   = $clog2(BLINK_TOGGLES + 1);
    localparam logic [6:0]  SegPol = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]  SelPol = {4{SEG_ACTIVE_LOW}};

    // Result capture: over_q resets high so a board already finished at reset is ignored.
    logic    over_q;
    logic    rise_q;
    winner_e win_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            over_q <= 1'b1;
            rise_q <= 1'b0;
            win_q  <= WIN_NONE_DRAW;
        end else begin
            over_q <= over;
            rise_q <= over & ~over_q;
            win_q  <= winner_e'(winner);
        end
    end

    logic upd_p1;
    logic upd_p2;
    logic upd_draw;
    logic upd_win;

    assign upd_p1   = rise_q && (win_q == WIN_P1);
    assign upd_p2   = rise_q && (win_q == WIN_P2);
    assign upd_draw = rise_q && (win_q == WIN_NONE_DRAW);
    assign upd_win  = upd_p1 | upd_p2;

    // Tallies
    logic [7:0] p1_q;
    logic [7:0] p2_q;
    logic [7:0] draw_q;
    logic [7:0] p1_inc;
    logic [7:0] p2_inc;
    logic [7:0] draw_inc;
    logic       event_q;

    bcd2_sat_inc u_inc_p1 (
        .value  (p1_q),
        .result (p1_inc)
    );

    bcd2_sat_inc u_inc_p2 (
        .value  (p2_q),
        .result (p2_inc)
    );

    bcd2_sat_inc u_inc_draw (
        .value  (draw_q),
        .result (draw_inc)
    );

    always_ff @(posedge clk) begin
        if (reset || clear_scores) begin
            p1_q    <= 8'h00;
            p2_q    <= 8'h00;
            draw_q  <= 8'h00;
            event_q <= 1'b0;
        end else begin
            if (upd_p1) begin
                p1_q <= p1_inc;
            end
            if (upd_p2) begin
                p2_q <= p2_inc;
            end
            if (upd_draw) begin
                draw_q <= draw_inc;
            end
            event_q <= upd_win | upd_draw;
        end
    end

    // Blink FSM
    blink_state_e      state_q;
    blink_state_e      state_d;
    logic [BlinkW-1:0] blink_cnt_q;
    logic [TogW-1:0]   toggles_q;
    logic              phase_q;
    winner_e           who_q;
    logic              blank_p1;
    logic              blank_p2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (upd_win) begin
                    state_d = StBlink;
                end
            end
            StBlink: begin
                if (toggles_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new win restarts blinking; clearing overrides everything.
        if (upd_win && (state_q == StBlink)) begin
            state_d = StBlink;
        end
        if (clear_scores) begin
            state_d = StIdle;
        end
    end

    always_comb begin
        blank_p1 = 1'b0;
        blank_p2 = 1'b0;
        if (state_q == StBlink && phase_q) begin
            blank_p1 = (who_q == WIN_P1);
            blank_p2 = (who_q == WIN_P2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear_scores) begin
            blink_cnt_q <= '0;
            toggles_q   <= '0;
            phase_q     <= 1'b0;
            who_q       <= WIN_NONE_DRAW;
        end else if (upd_win) begin
            blink_cnt_q <= '0;
            toggles_q   <= TogW'(BLINK_TOGGLES);
            phase_q     <= 1'b0;
            who_q       <= win_q;
        end else if (state_q == StBlink && toggles_q != '0) begin
            if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
                toggles_q   <= toggles_q - TogW'(1);
            end else begin
                blink_cnt_q <= blink_cnt_q + BlinkW'(1);
            end
        end
    end

    // Digit scan: index 0 drives dig_sel[3] (P1 tens) down to index 3 on dig_sel[0].
    logic [ScanW-1:0] scan_cnt_q;
    logic [1:0]       digit_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt_q <= '0;
            digit_q    <= 2'd0;
        end else if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            digit_q    <= digit_q + 2'd1;
        end else begin
            scan_cnt_q <= scan_cnt_q + ScanW'(1);
        end
    end

    logic [3:0] nibble;
    logic [3:0] sel_d;
    logic       blank;
    logic [6:0] seg_d;
    logic [6:0] seg_q;
    logic [3:0] dig_sel_q;

    always_comb begin
        nibble = 4'd0;
        sel_d  = 4'b1000;
        blank  = 1'b0;
        unique case (digit_q)
            2'd0: begin
                nibble = p1_q[7:4];
                sel_d  = 4'b1000;
                blank  = blank_p1;
            end
            2'd1: begin
                nibble = p1_q[3:0];
                sel_d  = 4'b0100;
                blank  = blank_p1;
            end
            2'd2: begin
                nibble = p2_q[7:4];
                sel_d  = 4'b0010;
                blank  = blank_p2;
            end
            2'd3: begin
                nibble = p2_q[3:0];
                sel_d  = 4'b0001;
                blank  = blank_p2;
            end
            default: ;
        endcase
        seg_d = blank ? 7'h00 : seg7_glyph(nibble);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q     <= seg7_glyph(4'd0) ^ SegPol;
            dig_sel_q <= 4'b1000 ^ SelPol;
        end else begin
            seg_q     <= seg_d ^ SegPol;
            dig_sel_q <= sel_d ^ SelPol;
        end
    end

    assign seg         = seg_q;
    assign dig_sel     = dig_sel_q;
    assign p1_bcd      = p1_q;
    assign p2_bcd      = p2_q;
    assign draw_bcd    = draw_q;
    assign score_event = event_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Directed bench for match_scoreboard with fast scan/blink dividers.
module tb_match_scoreboard;
    import match_scoreboard_pkg::*;

    logic       clk;
    logic       reset;
    logic       over;
    logic [1:0] winner;
    logic       clear_scores;
    logic [6:0] seg;
    logic [3:0] dig_sel;
    logic [7:0] p1_bcd;
    logic [7:0] p2_bcd;
    logic [7:0] draw_bcd;
    logic       score_event;

    int checks;
    int errors;

    match_scoreboard #(
        .SCAN_DIV       (4),
        .BLINK_DIV      (8),
        .BLINK_TOGGLES  (4),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .over         (over),
        .winner       (winner),
        .clear_scores (clear_scores),
        .seg          (seg),
        .dig_sel      (dig_sel),
        .p1_bcd       (p1_bcd),
        .p2_bcd       (p2_bcd),
        .draw_bcd     (draw_bcd),
        .score_event  (score_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One game result: over high for 'hold' cycles, then low for three.
    task automatic play(input logic [1:0] w, input int hold, output int n_evt,
                        output int first_at);
        n_evt    = 0;
        first_at = -1;
        @(negedge clk);
        over   = 1'b1;
        winner = w;
        for (int c = 1; c <= hold + 3; c++) begin
            @(negedge clk);
            if (c == hold) over = 1'b0;
            if (score_event) begin
                n_evt++;
                if (first_at < 0) first_at = c;
            end
        end
    endtask

    task automatic play_n(input logic [1:0] w, input int n);
        int ne;
        int fa;
        for (int i = 0; i < n; i++) play(w, 1, ne, fa);
    endtask

    // Checks one scan slot against the expected select and active-low glyph.
    task automatic check_slot(input string tag, input logic [3:0] exp_sel,
                              input logic [6:0] exp_seg);
        check_eq({tag, "_sel"}, 32'(dig_sel), 32'(exp_sel));
        check_eq({tag, "_seg"}, 32'(seg), 32'(exp_seg));
    endtask

    initial begin
        int ne;
        int fa;
        int evts;
        int bad;
        int blank_cnt;
        int bound;
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        over         = 1'b1;
        winner       = 2'b01;
        clear_scores = 1'b0;

        // Reset held with a finished board already present.
        repeat (3) @(negedge clk);
        check_eq("rst_dig_sel", 32'(dig_sel), 32'h7);
        check_eq("rst_seg", 32'(seg), 32'h40);
        check_eq("rst_event", 32'(score_event), 32'h0);
        reset = 1'b0;
        evts  = 0;
        repeat (6) begin
            @(negedge clk);
            if (score_event) evts++;
        end
        check_eq("rst_over_high_events", 32'(evts), 32'h0);
        check_eq("rst_p1", 32'(p1_bcd), 32'h00);
        check_eq("rst_p2", 32'(p2_bcd), 32'h00);
        check_eq("rst_draw", 32'(draw_bcd), 32'h00);
        over = 1'b0;
        @(negedge clk);

        // Ten P1 wins, each event exactly two clocks after the over rise.
        evts = 0;
        bad  = 0;
        for (int i = 0; i < 10; i++) begin
            play(2'b01, 2, ne, fa);
            evts += ne;
            if (ne != 1 || fa != 2) bad++;
        end
        check_eq("p1_ten_events", 32'(evts), 32'd10);
        check_eq("p1_latency_bad", 32'(bad), 32'd0);
        check_eq("p1_ten_tally", 32'(p1_bcd), 32'h10);
        check_eq("p1_blink_state", 32'(dut.state_q == StBlink), 32'h1);
        // Two odd phases of eight cycles each blank the P1 digits.
        blank_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (dut.blank_p1) blank_cnt++;
        end
        check_eq("p1_blank_cycles", 32'(blank_cnt), 32'd16);
        check_eq("p1_blink_done", 32'(dut.state_q == StIdle), 32'h1);

        // P2 up to saturation, then one more win.
        play_n(2'b10, 99);
        check_eq("p2_preset_99", 32'(p2_bcd), 32'h99);
        play(2'b10, 1, ne, fa);
        check_eq("p2_sat_tally", 32'(p2_bcd), 32'h99);
        check_eq("p2_sat_event", 32'(ne), 32'd1);
        check_eq("p2_sat_blink", 32'(dut.state_q == StBlink), 32'h1);
        repeat (40) @(negedge clk);

        // Long draw: one update, no blink.
        play(2'b00, 100, ne, fa);
        check_eq("draw_events", 32'(ne), 32'd1);
        check_eq("draw_tally", 32'(draw_bcd), 32'h01);
        check_eq("draw_idle", 32'(dut.state_q == StIdle), 32'h1);

        // Invalid winner code changes nothing.
        play(2'b11, 2, ne, fa);
        check_eq("bad_events", 32'(ne), 32'd0);
        check_eq("bad_tallies", {8'h0, p1_bcd, p2_bcd, draw_bcd}, 32'h00109901);

        // Clear coincident with a P1 update, while a P2 blink is running.
        play(2'b10, 1, ne, fa);
        @(negedge clk);
        over   = 1'b1;
        winner = 2'b01;
        @(negedge clk);
        clear_scores = 1'b1;
        @(negedge clk);
        clear_scores = 1'b0;
        check_eq("clr_tallies", {8'h0, p1_bcd, p2_bcd, draw_bcd}, 32'h0);
        check_eq("clr_idle", 32'(dut.state_q == StIdle), 32'h1);
        check_eq("clr_no_event", 32'(score_event), 32'h0);
        over = 1'b0;
        repeat (2) @(negedge clk);

        // Scan check with 37 : 05.
        play_n(2'b01, 37);
        play_n(2'b10, 5);
        repeat (45) @(negedge clk);
        check_eq("scan_p1", 32'(p1_bcd), 32'h37);
        check_eq("scan_p2", 32'(p2_bcd), 32'h05);
        bound = 0;
        while (dig_sel == 4'b0111 && bound < 40) begin
            @(negedge clk);
            bound++;
        end
        while (dig_sel != 4'b0111 && bound < 40) begin
            @(negedge clk);
            bound++;
        end
        check_eq("scan_align_timeout", 32'(bound < 40), 32'h1);
        check_slot("scan_d3", 4'b0111, 7'h30);
        repeat (4) @(negedge clk);
        check_slot("scan_d2", 4'b1011, 7'h78);
        repeat (4) @(negedge clk);
        check_slot("scan_d1", 4'b1101, 7'h40);
        repeat (4) @(negedge clk);
        check_slot("scan_d0", 4'b1110, 7'h12);
        repeat (4) @(negedge clk);
        check_slot("scan_wrap", 4'b0111, 7'h30);

        // Reset in the middle of a blink.
        play(2'b01, 1, ne, fa);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_idle", 32'(dut.state_q == StIdle), 32'h1);
        check_eq("midrst_p1", 32'(p1_bcd), 32'h00);
        check_eq("midrst_dig_sel", 32'(dig_sel), 32'h7);
        check_eq("midrst_seg", 32'(seg), 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
